// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Instruction-memory fetch channel between the PC sequencer and
//   instruction memory. A request is outstanding while imem_req is high;
//   it completes in the cycle where imem_req && imem_ready are both high,
//   and imem_rdata is sampled in that same cycle.
//
//   Signals:
//     imem_req    sequencer -> memory  fetch request valid
//     imem_addr   sequencer -> memory  fetch address (word aligned)
//     imem_ready  memory -> sequencer  request accepted/completed this cycle
//     imem_rdata  memory -> sequencer  instruction word for the request
//
//   Modports:
//     master  used by the sequencer (drives request and address)
//     slave   used by the memory (drives ready and read data)
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch-side controller that owns the program counter. It issues
//   instruction fetches over a valid/ready channel, hands completed
//   instructions to decode, and picks the next PC from trap, jump, branch
//   or sequential +4 (in that priority). Redirects that arrive while a
//   fetch is outstanding are parked in a pending register and applied when
//   that fetch completes, squashing the fetched instruction.
//
//   Ports:
//     clk            single clock, rising edge
//     rst            synchronous active-low reset
//     stall          blocks issue of new fetches (not an outstanding one)
//     halt           stop fetching until reset
//     trap           redirect to TRAP_VEC (highest priority)
//     jump           redirect to jump_target
//     jump_target    jump destination
//     branch_taken   redirect to branch_target
//     branch_target  branch destination
//     imem           fetch channel (master side)
//     pc_out         current PC register; imem_addr is wired to it
//     fetch_valid    one-cycle pulse: fetch_instr/fetch_pc are a live instr
//     fetch_instr    registered instruction word
//     fetch_pc       address of fetch_instr
//     misalign_err   one-cycle pulse: a redirect target was not word aligned
//     halted         high while in the HALT state
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 trap,
  input  logic                 jump,
  input  logic [31:0]          jump_target,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  pc_sequencer_if.master       imem,
  output logic [31:0]          pc_out,
  output logic                 fetch_valid,
  output logic [31:0]          fetch_instr,
  output logic [31:0]          fetch_pc,
  output logic                 misalign_err,
  output logic                 halted
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_IDLE = 2'd1,
    S_REQ  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;

  // Redirect parked while a fetch is outstanding.
  logic        pend_valid_q, pend_valid_d;
  logic        pend_trap_q, pend_trap_d;
  logic [31:0] pend_target_q, pend_target_d;

  // Halt seen during an outstanding fetch; honoured at completion.
  logic        halt_lat_q, halt_lat_d;

  logic        fetch_valid_q, fetch_valid_d;
  logic [31:0] fetch_instr_q, fetch_instr_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        misalign_q, misalign_d;

  // Combinational redirect selection for this cycle.
  logic        redir_req;
  logic        redir_trap;
  logic        redir_misalign;
  logic [31:0] redir_target;
  logic        new_wins;
  logic        complete;

  // Priority select: trap > jump > branch. A misaligned jump or branch
  // target is replaced by the trap vector and flagged. A misaligned target
  // is not treated as a trap for pending-overwrite purposes: only the trap
  // input makes a pending redirect sticky.
  always_comb begin
    redir_req      = trap | jump | branch_taken;
    redir_trap     = trap;
    redir_misalign = 1'b0;
    redir_target   = pc_q;
    if (trap) begin
      redir_target = TRAP_VEC;
    end else if (jump) begin
      if (jump_target[1:0] != 2'b00) begin
        redir_target   = TRAP_VEC;
        redir_misalign = 1'b1;
      end else begin
        redir_target = jump_target;
      end
    end else if (branch_taken) begin
      if (branch_target[1:0] != 2'b00) begin
        redir_target   = TRAP_VEC;
        redir_misalign = 1'b1;
      end else begin
        redir_target = branch_target;
      end
    end
  end

  // A redirect arriving this cycle replaces a pending one unless the
  // pending one is a trap and the new one is not.
  assign new_wins = redir_req && !(pend_valid_q && pend_trap_q && !redir_trap);
  assign complete = (state_q == S_REQ) && imem.imem_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_trap_d   = pend_trap_q;
    pend_target_d = pend_target_q;
    halt_lat_d    = halt_lat_q;
    fetch_valid_d = 1'b0;
    fetch_instr_d = fetch_instr_q;
    fetch_pc_d    = fetch_pc_q;
    misalign_d    = 1'b0;

    case (state_q)
      S_RST: begin
        state_d = S_IDLE;
      end

      S_IDLE: begin
        // Nothing outstanding: a redirect goes straight into the PC.
        misalign_d = redir_misalign;
        if (redir_req) begin
          pc_d = redir_target;
        end
        if (halt) begin
          state_d = S_HALT;
        end else if (!stall) begin
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        misalign_d = redir_misalign;
        if (complete) begin
          if (new_wins) begin
            pc_d = redir_target;
          end else if (pend_valid_q) begin
            pc_d = pend_target_q;
          end else begin
            fetch_valid_d = 1'b1;
            fetch_instr_d = imem.imem_rdata;
            fetch_pc_d    = pc_q;
            pc_d          = pc_q + 32'd4;
          end
          pend_valid_d = 1'b0;
          pend_trap_d  = 1'b0;
          halt_lat_d   = 1'b0;
          if (halt || halt_lat_q) begin
            state_d = S_HALT;
          end else if (stall) begin
            state_d = S_IDLE;
          end
        end else begin
          // Address must stay stable until completion, so park the target.
          if (new_wins) begin
            pend_valid_d  = 1'b1;
            pend_trap_d   = redir_trap;
            pend_target_d = redir_target;
          end
          if (halt) begin
            halt_lat_d = 1'b1;
          end
        end
      end

      S_HALT: begin
        // Frozen until reset.
      end

      default: begin
        state_d = S_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_RST;
      pc_q          <= RESET_VEC;
      pend_valid_q  <= 1'b0;
      pend_trap_q   <= 1'b0;
      pend_target_q <= 32'd0;
      halt_lat_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= 32'd0;
      fetch_pc_q    <= 32'd0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_trap_q   <= pend_trap_d;
      pend_target_q <= pend_target_d;
      halt_lat_q    <= halt_lat_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_pc_q    <= fetch_pc_d;
      misalign_q    <= misalign_d;
    end
  end

  // Request and halted are pure decodes of the state register.
  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign pc_out         = pc_q;
  assign fetch_valid    = fetch_valid_q;
  assign fetch_instr    = fetch_instr_q;
  assign fetch_pc       = fetch_pc_q;
  assign misalign_err   = misalign_q;
  assign halted         = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed bench for pc_sequencer. The instruction memory returns the
//   bitwise inverse of the requested address, so every fetched word can be
//   predicted from its address. Inputs change 1 ns after a rising edge and
//   outputs are checked at that same point.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        halt;
  logic        trap;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc_out;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        misalign_err;
  logic        halted;

  int n_checks;
  int n_fails;

  pc_sequencer_if imem_bus ();

  assign imem_bus.imem_rdata = ~imem_bus.imem_addr;

  pc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .halt          (halt),
    .trap          (trap),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem_bus),
    .pc_out        (pc_out),
    .fetch_valid   (fetch_valid),
    .fetch_instr   (fetch_instr),
    .fetch_pc      (fetch_pc),
    .misalign_err  (misalign_err),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, req);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    trap         = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b0;
    stall = 1'b0;
    halt = 1'b0;
    trap = 1'b0;
    jump = 1'b0;
    jump_target = 32'd0;
    branch_taken = 1'b0;
    branch_target = 32'd0;
    imem_bus.imem_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);

    // Reset release: RST -> IDLE -> REQ
    rst = 1'b1;
    step();
    chk("idle_req", {31'd0, imem_bus.imem_req}, 32'd0);
    step();
    chk("first_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("first_addr", imem_bus.imem_addr, 32'h0);
    chk("first_fv", {31'd0, fetch_valid}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("seq_addr", imem_bus.imem_addr, 32'(4 * i));
      chk("seq_fv", {31'd0, fetch_valid}, 32'd1);
      chk("seq_fpc", fetch_pc, 32'(4 * (i - 1)));
      chk("seq_instr", fetch_instr, ~32'(4 * (i - 1)));
    end

    // Wait states with a jump arriving mid-wait
    imem_bus.imem_ready = 1'b0;
    step();
    chk("wait_addr0", imem_bus.imem_addr, 32'hC);
    chk("wait_fv", {31'd0, fetch_valid}, 32'd0);
    jump = 1'b1;
    jump_target = 32'h40;
    step();
    clear_redirects();
    chk("wait_addr1", imem_bus.imem_addr, 32'hC);
    step();
    chk("wait_addr2", imem_bus.imem_addr, 32'hC);
    chk("wait_req", {31'd0, imem_bus.imem_req}, 32'd1);
    imem_bus.imem_ready = 1'b1;
    step();
    chk("squash_fv", {31'd0, fetch_valid}, 32'd0);
    chk("jump_addr", imem_bus.imem_addr, 32'h40);
    step();
    chk("jump_fv", {31'd0, fetch_valid}, 32'd1);
    chk("jump_fpc", fetch_pc, 32'h40);
    chk("jump_instr", fetch_instr, ~32'h40);

    // Pending trap is not overwritten by a later jump
    imem_bus.imem_ready = 1'b0;
    trap = 1'b1;
    step();
    trap = 1'b0;
    jump = 1'b1;
    jump_target = 32'h80;
    step();
    clear_redirects();
    chk("ptrap_hold", imem_bus.imem_addr, 32'h44);
    imem_bus.imem_ready = 1'b1;
    step();
    chk("ptrap_addr", imem_bus.imem_addr, 32'h100);
    chk("ptrap_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    chk("after_trap_addr", imem_bus.imem_addr, 32'h104);

    // trap, jump and branch together: trap wins
    trap = 1'b1;
    jump = 1'b1;
    jump_target = 32'h200;
    branch_taken = 1'b1;
    branch_target = 32'h300;
    step();
    clear_redirects();
    chk("prio_addr", imem_bus.imem_addr, 32'h100);
    chk("prio_fv", {31'd0, fetch_valid}, 32'd0);
    chk("prio_mis", {31'd0, misalign_err}, 32'd0);

    // Jump away, then a misaligned branch
    jump = 1'b1;
    jump_target = 32'h200;
    step();
    clear_redirects();
    chk("j200_addr", imem_bus.imem_addr, 32'h200);
    branch_taken = 1'b1;
    branch_target = 32'h22;
    step();
    clear_redirects();
    chk("mis_addr", imem_bus.imem_addr, 32'h100);
    chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
    step();
    chk("mis_clear", {31'd0, misalign_err}, 32'd0);
    chk("mis_next_fpc", fetch_pc, 32'h100);
    chk("mis_next_addr", imem_bus.imem_addr, 32'h104);

    // Wrap-around of sequential PC
    jump = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    step();
    clear_redirects();
    chk("wrap_pre", imem_bus.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr", imem_bus.imem_addr, 32'h0);
    chk("wrap_fpc", fetch_pc, 32'hFFFF_FFFC);

    // Stall mid-request: outstanding request still completes
    imem_bus.imem_ready = 1'b0;
    stall = 1'b1;
    step();
    chk("stall_req_held", {31'd0, imem_bus.imem_req}, 32'd1);
    imem_bus.imem_ready = 1'b1;
    step();
    chk("stall_req_drop", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("stall_fv", {31'd0, fetch_valid}, 32'd1);
    chk("stall_fpc", fetch_pc, 32'h0);
    chk("stall_addr", imem_bus.imem_addr, 32'h4);
    step();
    chk("stall_idle_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("stall_idle_fv", {31'd0, fetch_valid}, 32'd0);
    jump = 1'b1;
    jump_target = 32'h500;
    step();
    clear_redirects();
    chk("idle_jump_pc", pc_out, 32'h500);
    chk("idle_jump_req", {31'd0, imem_bus.imem_req}, 32'd0);
    stall = 1'b0;
    step();
    chk("unstall_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("unstall_addr", imem_bus.imem_addr, 32'h500);

    // Halt latched during a wait, honoured at completion
    imem_bus.imem_ready = 1'b0;
    halt = 1'b1;
    step();
    halt = 1'b0;
    imem_bus.imem_ready = 1'b1;
    step();
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("halt_fpc", fetch_pc, 32'h500);
    jump = 1'b1;
    jump_target = 32'h40;
    step();
    step();
    clear_redirects();
    chk("halt_pc_frozen", pc_out, 32'h504);
    chk("halt_still", {31'd0, halted}, 32'd1);
    chk("halt_fv", {31'd0, fetch_valid}, 32'd0);

    // One-cycle reset restarts fetching
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rerst_pc", pc_out, 32'h0);
    chk("rerst_halted", {31'd0, halted}, 32'd0);
    step();
    chk("rerst_idle", {31'd0, imem_bus.imem_req}, 32'd0);
    step();
    chk("rerst_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("rerst_addr", imem_bus.imem_addr, 32'h0);
    step();
    chk("rerst_fv", {31'd0, fetch_valid}, 32'd1);
    chk("rerst_fpc", fetch_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
